// File: rtl/updown_counter_arbiter.sv
// Shared WIDTH-bit up/down counter arbitrated round-robin among NUM_REQ requesters.
// Grant in IDLE, apply in EXEC, hold the response in RESP until rsp_ready.
module updown_counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_value,
  output logic [WIDTH-1:0]         count_out,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;

  // Scan from the highest offset down so the nearest valid index after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rr_ptr_d  = rr_ptr_q;
    op_d      = op_q;
    data_d    = data_q;
    id_d      = id_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld && !reset) begin
          req_ready[grant_idx] = 1'b1;
          op_d     = req_op[2*int'(grant_idx) +: 2];
          data_d   = req_data[WIDTH*int'(grant_idx) +: WIDTH];
          id_d     = grant_idx;
          rr_ptr_d = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          2'b01:   count_d = count_q + 1'b1;
          2'b10:   count_d = count_q - 1'b1;
          2'b11:   count_d = data_q;
          default: count_d = count_q;
        endcase
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rr_ptr_q <= '0;
      op_q     <= '0;
      data_q   <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      data_q   <= data_d;
      id_q     <= id_d;
    end
  end

  // The count cannot change in RESP, so the live register doubles as the held response.
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_value = count_q;
  assign count_out = count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_updown_counter_arbiter.sv
// Directed and randomized transactions against a transaction-level counter/round-robin model.
module tb_updown_counter_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_value;
  logic [W-1:0]   count_out;
  logic           busy;

  updown_counter_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_value(rsp_value), .count_out(count_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int m_count = 0;
  int m_rr    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++)
      if (mask[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic int apply_op(input int c, input logic [1:0] op, input logic [W-1:0] d);
    case (op)
      2'b00:   return c;
      2'b01:   return (c + 1) % 256;
      2'b10:   return (c + 255) % 256;
      default: return int'(d);
    endcase
  endfunction

  always @(negedge clk)
    if (!reset) chk("ready_onehot0", {31'b0, $onehot0(req_ready)}, 1);

  task automatic txn(input logic [N-1:0] mask, input logic [2*N-1:0] ops,
                     input logic [W*N-1:0] datas, input int stall);
    int g;
    req_valid = mask; req_op = ops; req_data = datas; rsp_ready = 1'b0;
    #1;
    g = pick(mask);
    chk("grant", req_ready, 32'(1 << g));
    chk("idle_busy", busy, 0);
    tick;
    m_count = apply_op(m_count, ops[2*g +: 2], datas[W*g +: W]);
    m_rr = (g + 1) % N;
    req_valid = '1; req_op = 8'($urandom); req_data = 32'($urandom);
    #1;
    chk("exec_ready", req_ready, 0);
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    tick;
    for (int s = 0; s <= stall; s++) begin
      chk("resp_valid", rsp_valid, 1);
      chk("resp_id", rsp_id, g);
      chk("resp_value", rsp_value, m_count);
      chk("resp_count", count_out, m_count);
      chk("resp_ready", req_ready, 0);
      if (s < stall) tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_count", count_out, m_count);
  endtask

  initial begin
    reset = 1'b1; req_valid = '1; req_op = '1; req_data = '1; rsp_ready = 1'b1;
    tick; tick;
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    #1;
    chk("reset_count", count_out, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_value", rsp_value, 0);
    chk("reset_busy", busy, 0);

    // Load 0x7F then increment, then wrap at both ends.
    txn(4'b0001, 8'b11, 32'h0000_007F, 0);
    txn(4'b0001, 8'b01, 32'h0, 0);
    chk("count_0x80", count_out, 32'h80);
    txn(4'b0001, 8'b11, 32'h0000_00FF, 0);
    txn(4'b0001, 8'b01, 32'h0, 0);
    chk("wrap_up", rsp_value, 0);
    txn(4'b0001, 8'b11, 32'h0, 0);
    txn(4'b0001, 8'b10, 32'h0, 0);
    chk("wrap_down", rsp_value, 32'hFF);

    // Reset during EXEC of a load 0x55.
    req_valid = 4'b0010; req_op = 8'b0000_1100; req_data = 32'h0000_5500;
    #1;
    chk("mid_grant", req_ready, 32'b0010);
    tick;
    reset = 1'b1; req_valid = '0;
    tick;
    reset = 1'b0;
    #1;
    chk("mid_count", count_out, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    m_count = 0; m_rr = 0;
    tick; tick;
    chk("mid_no_emit", rsp_valid, 0);

    // All requesters increment continuously: grants 0,1,2,3,0 with values 1..5.
    for (int i = 0; i < 5; i++) txn(4'hF, {N{2'b01}}, 32'h0, 0);
    chk("rr_value5", rsp_value, 5);

    // Long response stall with everyone pending.
    txn(4'hF, {N{2'b01}}, 32'h0, 5);

    // Lone requester 2, then rr_ptr=3 and requester 2 still granted at once.
    txn(4'b0100, 8'b0011_0000, 32'h0010_0000, 0);
    txn(4'b0100, 8'b0010_0000, 32'h0, 0);
    chk("dec_0x0f", rsp_value, 32'h0F);
    txn(4'b0100, 8'b0000_0000, 32'hFF00_FFFF, 0);
    chk("read_hold", count_out, 32'h0F);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] m;
      m = 4'($urandom_range(1, 15));
      txn(m, 8'($urandom), 32'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
